// File: rtl/vend_pkg.sv
// vend_pkg: state encoding and price/select helpers shared by the vending controller.
package vend_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_CREDIT   = 2'd1,
        ST_DISPENSE = 2'd2,
        ST_CHANGE   = 2'd3
    } state_t;

    // Prices arrive packed into at most 8 products of at most 8 bits each.
    function automatic logic [7:0] price_of(input logic [63:0] prices, input int w, input logic [2:0] idx);
        return 8'(prices >> (int'(idx) * w)) & 8'((16'd1 << w) - 16'd1);
    endfunction

    function automatic logic [2:0] lowest_set(input logic [7:0] sel);
        logic [2:0] r;
        r = '0;
        for (int i = 7; i >= 0; i--) if (sel[i]) r = 3'(i);
        return r;
    endfunction

    function automatic bit cfg_ok(input logic [63:0] prices, input int n, input int w, input int max_credit);
        bit ok;
        ok = n >= 1 && n <= 8 && w >= 1 && w <= 8 && max_credit >= 1 && max_credit < (1 << w);
        for (int i = 0; i < 8; i++)
            if (i < n && (int'(price_of(prices, w, 3'(i))) < 1 || int'(price_of(prices, w, 3'(i))) > max_credit))
                ok = 1'b0;
        return ok;
    endfunction

endpackage

// File: rtl/vend_timeout_timer.sv
// vend_timeout_timer: counts consecutive enabled, uncleared cycles and flags the last one.
module vend_timeout_timer #(
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic en_i,
    output logic expire_o
);

    localparam int CW = $clog2(TIMEOUT_CYC + 1);

    logic [CW-1:0] count_q, count_d;

    assign count_d  = (clr_i || !en_i) ? '0 : count_q + CW'(1);
    assign expire_o = en_i && !clr_i && count_q == CW'(TIMEOUT_CYC - 1);

    always_ff @(posedge clk or posedge rst)
        if (rst) count_q <= '0;
        else     count_q <= count_d;

endmodule

// File: rtl/vend_ctrl_multi.sv
// vend_ctrl_multi: parametrised Moore vending controller with refund and unit change return.
// Define VEND_TIMEOUT_EN to auto-refund after TIMEOUT_CYC idle cycles holding credit.
module vend_ctrl_multi
    import vend_pkg::*;
#(
    parameter int                         N_PROD      = 4,
    parameter int                         CREDIT_W    = 4,
    parameter int                         MAX_CREDIT  = 9,
    parameter logic [N_PROD*CREDIT_W-1:0] PRICES      = {4'd5, 4'd3, 4'd2, 4'd1},
    parameter int                         TIMEOUT_CYC = 1024
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_coin,
    input  logic [N_PROD-1:0]   i_sel,
    input  logic                i_refund,
    output logic [N_PROD-1:0]   o_led,
    output logic [N_PROD-1:0]   o_dispense,
    output logic                o_change,
    output logic                o_coin_reject,
    output logic [CREDIT_W-1:0] o_credit
);

    localparam logic [63:0] PRICES64 = 64'(PRICES);
    localparam bit          CFG_OK   = cfg_ok(PRICES64, N_PROD, CREDIT_W, MAX_CREDIT) && TIMEOUT_CYC >= 1;

    if (!CFG_OK) begin : g_bad_cfg
        $error("vend_ctrl_multi: invalid parameters");
    end

    state_t              state_q, state_d;
    logic [CREDIT_W-1:0] credit_q, credit_d;
    logic [2:0]          idx_q, idx_d;
    logic                reject_q, reject_d;
    logic [2:0]          sel_idx;
    logic [CREDIT_W-1:0] sel_price;
    logic                sel_ok;
    logic                expire;

    assign sel_idx   = lowest_set(8'(i_sel));
    assign sel_price = CREDIT_W'(price_of(PRICES64, CREDIT_W, sel_idx));
    assign sel_ok    = (|i_sel) && credit_q >= sel_price;

`ifdef VEND_TIMEOUT_EN
    vend_timeout_timer #(
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .clr_i    (i_coin | i_refund | (|i_sel)),
        .en_i     (state_q == ST_CREDIT),
        .expire_o (expire)
    );
`else
    assign expire = 1'b0;
`endif

    // A coin is rejected unless the idle/credit path explicitly accepts it.
    always_comb begin
        state_d  = state_q;
        credit_d = credit_q;
        idx_d    = idx_q;
        reject_d = i_coin;
        case (state_q)
            ST_IDLE, ST_CREDIT: begin
                if (i_refund && credit_q != '0) begin
                    state_d = ST_CHANGE;
                end else if (sel_ok) begin
                    idx_d    = sel_idx;
                    credit_d = credit_q - sel_price;
                    state_d  = ST_DISPENSE;
                end else if (expire) begin
                    state_d = ST_CHANGE;
                end else if (i_coin && credit_q < CREDIT_W'(MAX_CREDIT)) begin
                    credit_d = credit_q + CREDIT_W'(1);
                    state_d  = ST_CREDIT;
                    reject_d = 1'b0;
                end
            end
            ST_DISPENSE: state_d = credit_q != '0 ? ST_CREDIT : ST_IDLE;
            default: begin
                credit_d = credit_q - CREDIT_W'(1);
                state_d  = credit_q == CREDIT_W'(1) ? ST_IDLE : ST_CHANGE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state_q  <= ST_IDLE;
            credit_q <= '0;
            idx_q    <= '0;
            reject_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            credit_q <= credit_d;
            idx_q    <= idx_d;
            reject_q <= reject_d;
        end

    always_comb begin
        o_led = '0;
        for (int i = 0; i < N_PROD; i++)
            o_led[i] = (state_q == ST_IDLE || state_q == ST_CREDIT)
                       && credit_q >= CREDIT_W'(price_of(PRICES64, CREDIT_W, 3'(i)));
    end

    assign o_dispense    = state_q == ST_DISPENSE ? N_PROD'(1) << idx_q : '0;
    assign o_change      = state_q == ST_CHANGE;
    assign o_coin_reject = reject_q;
    assign o_credit      = credit_q;

endmodule
